// File: rtl/prime_display.sv
// prime_display: checks a prime-counter sequence (2,3,5,7,11,13), counts laps
// and drives a two-digit multiplexed seven-segment display of the last sample.
module prime_display #(
   parameter int unsigned REFRESH_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_en,
   input  logic [3:0] qn,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic [3:0] cur_val,
   output logic [7:0] lap_cnt,
   output logic       seq_err
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   logic [3:0]       cur_val_q,   cur_val_d;
   logic             have_prev_q, have_prev_d;
   logic             seq_err_q,   seq_err_d;
   logic [7:0]       lap_cnt_q,   lap_cnt_d;
   logic [CNT_W-1:0] refresh_q,   refresh_d;
   logic             digit_sel_q, digit_sel_d;
   logic [1:0]       an_q,        an_d;
   logic [6:0]       seg_q,       seg_d;

   logic             tens_c;
   logic [3:0]       ones_c;

   // Membership in the legal prime set.
   function automatic logic is_legal(input logic [3:0] v);
      case (v)
         4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: is_legal = 1'b1;
         default:                              is_legal = 1'b0;
      endcase
   endfunction

   // True when nxt is the legal successor of prev (13 wraps to 2).
   function automatic logic legal_next(input logic [3:0] prev, input logic [3:0] nxt);
      case (prev)
         4'd2:    legal_next = (nxt == 4'd3);
         4'd3:    legal_next = (nxt == 4'd5);
         4'd5:    legal_next = (nxt == 4'd7);
         4'd7:    legal_next = (nxt == 4'd11);
         4'd11:   legal_next = (nxt == 4'd13);
         4'd13:   legal_next = (nxt == 4'd2);
         default: legal_next = 1'b0;
      endcase
   endfunction

   // Active-high abcdefg code; values above 9 are blank.
   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 7'b1111110;
         4'd1:    seg_code = 7'b0110000;
         4'd2:    seg_code = 7'b1101101;
         4'd3:    seg_code = 7'b1111001;
         4'd4:    seg_code = 7'b0110011;
         4'd5:    seg_code = 7'b1011011;
         4'd6:    seg_code = 7'b1011111;
         4'd7:    seg_code = 7'b1110000;
         4'd8:    seg_code = 7'b1111111;
         4'd9:    seg_code = 7'b1111011;
         default: seg_code = SEG_BLANK;
      endcase
   endfunction

   // Next-state logic: sample capture, sequence check, lap count, scan and display.
   always_comb begin
      cur_val_d   = cur_val_q;
      have_prev_d = have_prev_q;
      seq_err_d   = seq_err_q;
      lap_cnt_d   = lap_cnt_q;
      refresh_d   = refresh_q;
      digit_sel_d = digit_sel_q;
      an_d        = an_q;
      seg_d       = seg_q;
      tens_c      = 1'b0;
      ones_c      = cur_val_q;

      if (sample_en) begin
         cur_val_d   = qn;
         have_prev_d = 1'b1;
         if (have_prev_q) begin
            if (!legal_next(cur_val_q, qn)) begin
               seq_err_d = 1'b1;
            end
            if ((cur_val_q == 4'd13) && (qn == 4'd2) && (lap_cnt_q != 8'hFF)) begin
               lap_cnt_d = lap_cnt_q + 8'd1;
            end
         end else if (!is_legal(qn)) begin
            seq_err_d = 1'b1;
         end
      end

      if (refresh_q == CNT_LAST) begin
         refresh_d   = '0;
         digit_sel_d = ~digit_sel_q;
      end else begin
         refresh_d   = refresh_q + CNT_W'(1);
      end

      if (cur_val_q >= 4'd10) begin
         tens_c = 1'b1;
         ones_c = cur_val_q - 4'd10;
      end

      // an and seg both follow the current digit_sel so they stay paired.
      an_d = digit_sel_q ? 2'b10 : 2'b01;
      if (!have_prev_q) begin
         seg_d = SEG_BLANK;
      end else if (digit_sel_q) begin
         seg_d = tens_c ? seg_code(4'd1) : SEG_BLANK;
      end else begin
         seg_d = seg_code(ones_c);
      end
   end

   // State registers with synchronous reset overriding everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_val_q   <= 4'd0;
         have_prev_q <= 1'b0;
         seq_err_q   <= 1'b0;
         lap_cnt_q   <= 8'd0;
         refresh_q   <= '0;
         digit_sel_q <= 1'b0;
         an_q        <= 2'b01;
         seg_q       <= SEG_BLANK;
      end else begin
         cur_val_q   <= cur_val_d;
         have_prev_q <= have_prev_d;
         seq_err_q   <= seq_err_d;
         lap_cnt_q   <= lap_cnt_d;
         refresh_q   <= refresh_d;
         digit_sel_q <= digit_sel_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
      end
   end

   assign seg     = seg_q;
   assign an      = an_q;
   assign cur_val = cur_val_q;
   assign lap_cnt = lap_cnt_q;
   assign seq_err = seq_err_q;

endmodule

// File: tb/tb_prime_display.sv
// Self-checking bench for prime_display: vector table with scoreboard plus
// hand-written scan, saturation and reset sequences.
module tb_prime_display;

   logic       clk = 1'b0;
   logic       rst;
   logic       sample_en;
   logic [3:0] qn;
   logic [6:0] seg,  seg1;
   logic [1:0] an,   an1;
   logic [3:0] cur_val, cur_val1;
   logic [7:0] lap_cnt, lap_cnt1;
   logic       seq_err, seq_err1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   prime_display #(.REFRESH_DIV(4)) dut (
      .clk(clk), .rst(rst), .sample_en(sample_en), .qn(qn),
      .seg(seg), .an(an), .cur_val(cur_val), .lap_cnt(lap_cnt), .seq_err(seq_err)
   );

   prime_display #(.REFRESH_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .sample_en(sample_en), .qn(qn),
      .seg(seg1), .an(an1), .cur_val(cur_val1), .lap_cnt(lap_cnt1), .seq_err(seq_err1)
   );

   typedef struct {
      logic       rst;
      logic       se;
      logic [3:0] qn;
      logic [3:0] cv;
      logic       err;
      logic [7:0] lap;
   } vec_t;

   typedef struct {
      logic [3:0] cv;
      logic       err;
      logic [7:0] lap;
      int         idx;
   } exp_t;

   vec_t vq[$];
   exp_t sb[$];

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic se, input logic [3:0] q,
                      input logic [3:0] cv, input logic err, input logic [7:0] lap);
      vec_t v;
      v.rst = r; v.se = se; v.qn = q; v.cv = cv; v.err = err; v.lap = lap;
      vq.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sample_en = 1'b0;
      qn = 4'd0;
      tick();
      rst = 1'b0;
   endtask

   task automatic sample(input logic [3:0] v);
      sample_en = 1'b1;
      qn = v;
      tick();
      sample_en = 1'b0;
   endtask

   // Reset, optionally sample v once, then follow 12 edges of scanning on both
   // instances. With divide-by-4 the digit flips every 4 edges, with divide-by-1
   // every edge; the first edge after the sample still shows blank.
   task automatic scan_check(input string nm, input bit do_sample, input logic [3:0] v,
                             input logic [6:0] ones_s, input logic [6:0] tens_s);
      int ph, ph1;
      logic [6:0] es, es1;
      do_reset();
      sample_en = do_sample;
      qn = v;
      for (int k = 1; k <= 12; k++) begin
         tick();
         sample_en = 1'b0;
         ph  = ((k - 1) / 4) % 2;
         ph1 = (k - 1) % 2;
         if (k == 1 || !do_sample) begin
            es = 7'b0; es1 = 7'b0;
         end else begin
            es  = ph  ? tens_s : ones_s;
            es1 = ph1 ? tens_s : ones_s;
         end
         chk($sformatf("%s an k=%0d", nm, k), int'(an), ph ? 2 : 1);
         chk($sformatf("%s seg k=%0d", nm, k), int'(seg), int'(es));
         chk($sformatf("%s div1 an k=%0d", nm, k), int'(an1), ph1 ? 2 : 1);
         chk($sformatf("%s div1 seg k=%0d", nm, k), int'(seg1), int'(es1));
      end
      if (do_sample) chk($sformatf("%s div1 cur_val", nm), int'(cur_val1), int'(v));
   endtask

   initial begin
      rst = 1'b1;
      sample_en = 1'b0;
      qn = 4'd0;

      // rst se qn  -> cur_val seq_err lap_cnt
      add(1, 0, 0,    0, 0, 0);
      add(0, 1, 2,    2, 0, 0);
      add(0, 1, 3,    3, 0, 0);
      add(0, 1, 5,    5, 0, 0);
      add(0, 1, 7,    7, 0, 0);
      add(0, 1, 11,  11, 0, 0);
      add(0, 1, 13,  13, 0, 0);
      add(0, 1, 2,    2, 0, 1);
      add(0, 0, 9,    2, 0, 1);
      add(0, 1, 3,    3, 0, 1);
      add(0, 1, 3,    3, 1, 1);
      add(0, 1, 5,    5, 1, 1);
      add(1, 1, 7,    0, 0, 0);
      add(0, 1, 4,    4, 1, 0);
      add(1, 0, 0,    0, 0, 0);
      add(0, 1, 5,    5, 0, 0);
      add(0, 1, 7,    7, 0, 0);
      add(1, 0, 0,    0, 0, 0);
      add(0, 1, 2,    2, 0, 0);
      add(0, 1, 3,    3, 0, 0);
      add(0, 1, 7,    7, 1, 0);
      add(0, 1, 11,  11, 1, 0);
      add(0, 1, 13,  13, 1, 0);
      add(0, 1, 2,    2, 1, 1);
      add(1, 0, 0,    0, 0, 0);
      add(0, 1, 13,  13, 0, 0);
      add(0, 1, 2,    2, 0, 1);
      add(0, 1, 0,    0, 1, 1);

      foreach (vq[i]) begin
         exp_t e;
         exp_t got;
         rst = vq[i].rst;
         sample_en = vq[i].se;
         qn = vq[i].qn;
         e.cv = vq[i].cv; e.err = vq[i].err; e.lap = vq[i].lap; e.idx = i;
         sb.push_back(e);
         tick();
         got = sb.pop_front();
         chk($sformatf("vec%0d cur_val", got.idx), int'(cur_val), int'(got.cv));
         chk($sformatf("vec%0d seq_err", got.idx), int'(seq_err), int'(got.err));
         chk($sformatf("vec%0d lap_cnt", got.idx), int'(lap_cnt), int'(got.lap));
      end
      rst = 1'b0;
      sample_en = 1'b0;

      // Reset values of the display outputs.
      do_reset();
      do_reset();
      chk("reset an", int'(an), 1);
      chk("reset seg", int'(seg), 0);

      // Display scanning for several captured values, and blanking with no sample.
      scan_check("v13", 1'b1, 4'd13, 7'b1111001, 7'b0110000);
      scan_check("v7",  1'b1, 4'd7,  7'b1110000, 7'b0000000);
      scan_check("v11", 1'b1, 4'd11, 7'b0110000, 7'b0110000);
      scan_check("v10", 1'b1, 4'd10, 7'b1111110, 7'b0110000);
      scan_check("none", 1'b0, 4'd2, 7'b0000000, 7'b0000000);

      // Lap counter saturation over 300 legal laps.
      do_reset();
      sample(4'd2);
      for (int lap = 1; lap <= 300; lap++) begin
         sample(4'd3);
         sample(4'd5);
         sample(4'd7);
         sample(4'd11);
         sample(4'd13);
         sample(4'd2);
         if (lap == 100) chk("lap_cnt at 100", int'(lap_cnt), 100);
         if (lap == 255) chk("lap_cnt at 255", int'(lap_cnt), 255);
      end
      chk("lap_cnt saturated", int'(lap_cnt), 255);
      chk("lap seq_err", int'(seq_err), 0);
      chk("lap cur_val", int'(cur_val), 2);

      // Reset with sample_en high wins over the sample.
      rst = 1'b1;
      sample_en = 1'b1;
      qn = 4'd3;
      tick();
      rst = 1'b0;
      sample_en = 1'b0;
      chk("rst+se seg", int'(seg), 0);
      chk("rst+se an", int'(an), 1);
      chk("rst+se cur_val", int'(cur_val), 0);
      chk("rst+se lap_cnt", int'(lap_cnt), 0);
      chk("rst+se seq_err", int'(seq_err), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
